// File: rtl/btb_npc_generator_if.sv
// Fetch/EX-side signal bundle between the pipeline and the BTB next-PC generator.
// The pipeline side drives the PCs and branch resolution information.
// The generator side returns the next PC, the prediction and the performance counters.
interface btb_npc_generator_if;
   logic [31:0] PCF;
   logic [31:0] PCE;
   logic        BrInstE;
   logic        BranchE;
   logic [31:0] BranchTarget;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        JalD;
   logic [31:0] JalTarget;
   logic        JalrE;
   logic [31:0] JalrTarget;
   logic        StallE;
   logic [31:0] PC_In;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        MispredictE;
   logic [31:0] BrCount;
   logic [31:0] MissCount;

   modport master (
      output PCF, PCE, BrInstE, BranchE, BranchTarget, PredTakenE, PredTargetE,
             JalD, JalTarget, JalrE, JalrTarget, StallE,
      input  PC_In, PredTakenF, PredTargetF, MispredictE, BrCount, MissCount
   );

   modport slave (
      input  PCF, PCE, BrInstE, BranchE, BranchTarget, PredTakenE, PredTargetE,
             JalD, JalTarget, JalrE, JalrTarget, StallE,
      output PC_In, PredTakenF, PredTargetF, MispredictE, BrCount, MissCount
   );
endinterface

// File: rtl/btb_npc_generator.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// It produces the next fetch PC from the BTB prediction, jal/jalr redirects and
// EX-stage mispredict recovery, and counts resolved branches and mispredictions.
// The lookup is combinational on PCF against the registered table. An update from
// the EX stage becomes visible on the cycle after its clock edge.
module btb_npc_generator #(
   parameter int         ENTRIES  = 64,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic CPU_CLK,
   input logic CPU_RST,
   btb_npc_generator_if.slave bus
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       cnt_q    [ENTRIES];

   logic [31:0] brCount_q, brCount_d;
   logic [31:0] missCount_q, missCount_d;

   logic [IDX_W-1:0] lookIdx;
   logic [TAG_W-1:0] lookTag;
   logic             lookHit;
   logic [31:0]      pcfPlus4;
   logic [31:0]      pcePlus4;
   logic             predTaken;
   logic [31:0]      predTarget;
   logic             mispredict;
   logic [31:0]      nextPc;

   logic             updEn;
   logic [IDX_W-1:0] updIdx;
   logic [TAG_W-1:0] updTag;
   logic             updHit;
   logic             entryWrite_d;
   logic             newValid_d;
   logic [TAG_W-1:0] newTag_d;
   logic [31:0]      newTarget_d;
   logic [1:0]       newCnt_d;

   assign lookIdx  = bus.PCF[IDX_W+1:2];
   assign lookTag  = bus.PCF[31:IDX_W+2];
   assign pcfPlus4 = bus.PCF + 32'd4;
   assign pcePlus4 = bus.PCE + 32'd4;
   assign updIdx   = bus.PCE[IDX_W+1:2];
   assign updTag   = bus.PCE[31:IDX_W+2];
   assign updEn    = bus.BrInstE & ~bus.StallE;

   // Fetch-side lookup: a hit with the counter's upper bit set predicts taken.
   // Reset suppresses the prediction so that fetch simply walks sequentially.
   always_comb begin
      lookHit    = valid_q[lookIdx] && (tag_q[lookIdx] == lookTag);
      predTaken  = ~CPU_RST & lookHit & cnt_q[lookIdx][1];
      predTarget = lookHit ? target_q[lookIdx] : pcfPlus4;
   end

   // Mispredict detection and next-PC selection. The EX-stage recovery overrides
   // jalr, jalr overrides jal, and jal overrides the fetch prediction.
   always_comb begin
      mispredict = ~CPU_RST & bus.BrInstE & ~bus.StallE &
                   ((bus.BranchE != bus.PredTakenE) |
                    (bus.BranchE & bus.PredTakenE & (bus.PredTargetE != bus.BranchTarget)));
      nextPc = pcfPlus4;
      if (CPU_RST)
         nextPc = pcfPlus4;
      else if (mispredict)
         nextPc = bus.BranchE ? bus.BranchTarget : pcePlus4;
      else if (bus.JalrE)
         nextPc = bus.JalrTarget;
      else if (bus.JalD)
         nextPc = bus.JalTarget;
      else if (predTaken)
         nextPc = predTarget;
   end

   // New contents for the entry addressed by the EX branch. A hit trains the counter
   // and refreshes the target on a taken branch. A taken miss allocates the entry as
   // weakly taken. A not-taken miss leaves the table untouched.
   always_comb begin
      updHit       = valid_q[updIdx] && (tag_q[updIdx] == updTag);
      entryWrite_d = 1'b0;
      newValid_d   = valid_q[updIdx];
      newTag_d     = tag_q[updIdx];
      newTarget_d  = target_q[updIdx];
      newCnt_d     = cnt_q[updIdx];
      if (updEn) begin
         if (updHit) begin
            entryWrite_d = 1'b1;
            if (bus.BranchE) begin
               newTarget_d = bus.BranchTarget;
               if (cnt_q[updIdx] != 2'b11)
                  newCnt_d = cnt_q[updIdx] + 2'b01;
            end else if (cnt_q[updIdx] != 2'b00) begin
               newCnt_d = cnt_q[updIdx] - 2'b01;
            end
         end else if (bus.BranchE) begin
            entryWrite_d = 1'b1;
            newValid_d   = 1'b1;
            newTag_d     = updTag;
            newTarget_d  = bus.BranchTarget;
            newCnt_d     = 2'b10;
         end
      end
   end

   // Performance counters stick at all-ones instead of wrapping.
   always_comb begin
      brCount_d   = brCount_q;
      missCount_d = missCount_q;
      if (updEn && (brCount_q != 32'hFFFF_FFFF))
         brCount_d = brCount_q + 32'd1;
      if (mispredict && (missCount_q != 32'hFFFF_FFFF))
         missCount_d = missCount_q + 32'd1;
   end

   // Table storage. Reset wipes every entry and takes priority over a pending update.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'd0;
            cnt_q[i]    <= CNT_INIT;
         end
      end else if (entryWrite_d) begin
         valid_q[updIdx]  <= newValid_d;
         tag_q[updIdx]    <= newTag_d;
         target_q[updIdx] <= newTarget_d;
         cnt_q[updIdx]    <= newCnt_d;
      end
   end

   // Performance counter registers.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         brCount_q   <= 32'd0;
         missCount_q <= 32'd0;
      end else begin
         brCount_q   <= brCount_d;
         missCount_q <= missCount_d;
      end
   end

   assign bus.PC_In       = nextPc;
   assign bus.PredTakenF  = predTaken;
   assign bus.PredTargetF = predTarget;
   assign bus.MispredictE = mispredict;
   assign bus.BrCount     = brCount_q;
   assign bus.MissCount   = missCount_q;

endmodule

// File: tb/tb_btb_npc_generator.sv
// Scoreboard bench for the BTB next-PC generator.
// Inputs are driven after the falling edge. The expected outputs for that cycle are
// queued, then popped and compared a little later, well before the next rising edge.
// A behavioural table model supplies the expectations. Key scenarios are also
// checked against literal values.
module tb_btb_npc_generator;

   typedef struct {
      logic        rst;
      logic [31:0] pcf;
      logic [31:0] pce;
      logic        brInst;
      logic        branch;
      logic [31:0] brTarget;
      logic        predTakenE;
      logic [31:0] predTargetE;
      logic        jalD;
      logic [31:0] jalTarget;
      logic        jalrE;
      logic [31:0] jalrTarget;
      logic        stallE;
   } stimT;

   typedef struct {
      string       name;
      logic        predTaken;
      logic [31:0] predTarget;
      logic        misp;
      logic [31:0] pcIn;
      logic [31:0] brCnt;
      logic [31:0] missCnt;
   } expT;

   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;
   expT  sbQ[$];

   logic        mValid  [64];
   logic [23:0] mTag    [64];
   logic [31:0] mTarget [64];
   logic [1:0]  mCnt    [64];
   logic [31:0] mBr;
   logic [31:0] mMiss;

   btb_npc_generator_if ifc ();

   btb_npc_generator #(.ENTRIES(64), .CNT_INIT(2'b01)) dut (
      .CPU_CLK (clk),
      .CPU_RST (rst),
      .bus     (ifc.slave)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   function automatic stimT idleStim(input logic [31:0] pcf);
      stimT s;
      s.rst = 1'b0;         s.pcf = pcf;           s.pce = 32'h0;
      s.brInst = 1'b0;      s.branch = 1'b0;       s.brTarget = 32'h0;
      s.predTakenE = 1'b0;  s.predTargetE = 32'h0; s.jalD = 1'b0;
      s.jalTarget = 32'h0;  s.jalrE = 1'b0;        s.jalrTarget = 32'h0;
      s.stallE = 1'b0;
      return s;
   endfunction

   function automatic stimT branchStim(input logic [31:0] pcf, input logic [31:0] pce, input logic taken,
                                       input logic [31:0] tgt, input logic predT, input logic [31:0] predTgt);
      stimT s;
      s = idleStim(pcf);
      s.pce = pce;          s.brInst = 1'b1;       s.branch = taken;
      s.brTarget = tgt;     s.predTakenE = predT;  s.predTargetE = predTgt;
      return s;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) begin
         mValid[i] = 1'b0; mTag[i] = 24'h0; mTarget[i] = 32'h0; mCnt[i] = 2'b01;
      end
      mBr = 32'h0;
      mMiss = 32'h0;
   endtask

   task automatic checkScoreboard();
      expT e;
      if (sbQ.size() == 0) begin
         checkOutput("scoreboard.empty", 32'd0, 32'd1);
         return;
      end
      e = sbQ.pop_front();
      checkOutput({e.name, ".predTakenF"}, {31'b0, ifc.PredTakenF}, {31'b0, e.predTaken});
      checkOutput({e.name, ".predTargetF"}, ifc.PredTargetF, e.predTarget);
      checkOutput({e.name, ".mispredictE"}, {31'b0, ifc.MispredictE}, {31'b0, e.misp});
      checkOutput({e.name, ".pcIn"}, ifc.PC_In, e.pcIn);
      checkOutput({e.name, ".brCount"}, ifc.BrCount, e.brCnt);
      checkOutput({e.name, ".missCount"}, ifc.MissCount, e.missCnt);
   endtask

   // Drive one cycle of stimulus, queue the model's expectations, check them, then
   // advance the model to the state the DUT holds after the coming rising edge.
   task automatic applyStimulus(input string name, input stimT s);
      expT         e;
      logic [5:0]  li, ui;
      logic        hit, uhit;
      @(negedge clk);
      rst = s.rst;
      ifc.PCF = s.pcf;               ifc.PCE = s.pce;
      ifc.BrInstE = s.brInst;        ifc.BranchE = s.branch;
      ifc.BranchTarget = s.brTarget; ifc.PredTakenE = s.predTakenE;
      ifc.PredTargetE = s.predTargetE;
      ifc.JalD = s.jalD;             ifc.JalTarget = s.jalTarget;
      ifc.JalrE = s.jalrE;           ifc.JalrTarget = s.jalrTarget;
      ifc.StallE = s.stallE;

      li  = s.pcf[7:2];
      hit = mValid[li] && (mTag[li] == s.pcf[31:8]);
      e.name       = name;
      e.predTaken  = !s.rst && hit && mCnt[li][1];
      e.predTarget = hit ? mTarget[li] : s.pcf + 32'd4;
      e.misp       = !s.rst && s.brInst && !s.stallE &&
                     ((s.branch != s.predTakenE) ||
                      (s.branch && s.predTakenE && (s.predTargetE != s.brTarget)));
      if (s.rst)            e.pcIn = s.pcf + 32'd4;
      else if (e.misp)      e.pcIn = s.branch ? s.brTarget : s.pce + 32'd4;
      else if (s.jalrE)     e.pcIn = s.jalrTarget;
      else if (s.jalD)      e.pcIn = s.jalTarget;
      else if (e.predTaken) e.pcIn = e.predTarget;
      else                  e.pcIn = s.pcf + 32'd4;
      e.brCnt   = mBr;
      e.missCnt = mMiss;
      sbQ.push_back(e);

      #2;
      checkScoreboard();

      if (s.rst) begin
         modelReset();
      end else begin
         if (e.misp && mMiss != 32'hFFFF_FFFF) mMiss = mMiss + 32'd1;
         if (s.brInst && !s.stallE) begin
            if (mBr != 32'hFFFF_FFFF) mBr = mBr + 32'd1;
            ui   = s.pce[7:2];
            uhit = mValid[ui] && (mTag[ui] == s.pce[31:8]);
            if (uhit) begin
               if (s.branch) begin
                  mTarget[ui] = s.brTarget;
                  if (mCnt[ui] != 2'b11) mCnt[ui] = mCnt[ui] + 2'b01;
               end else if (mCnt[ui] != 2'b00) begin
                  mCnt[ui] = mCnt[ui] - 2'b01;
               end
            end else if (s.branch) begin
               mValid[ui] = 1'b1; mTag[ui] = s.pce[31:8];
               mTarget[ui] = s.brTarget; mCnt[ui] = 2'b10;
            end
         end
      end
   endtask

   initial begin
      stimT s;
      assertCount = 0;
      failCount   = 0;
      modelReset();
      rst = 1'b1;
      s = idleStim(32'h100);
      ifc.PCF = s.pcf;          ifc.PCE = 32'h0;        ifc.BrInstE = 1'b0;
      ifc.BranchE = 1'b0;       ifc.BranchTarget = 32'h0; ifc.PredTakenE = 1'b0;
      ifc.PredTargetE = 32'h0;  ifc.JalD = 1'b0;        ifc.JalTarget = 32'h0;
      ifc.JalrE = 1'b0;         ifc.JalrTarget = 32'h0; ifc.StallE = 1'b0;
      repeat (2) @(posedge clk);

      // Reset held while a would-be allocating branch is in EX.
      s = branchStim(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      s.rst = 1'b1;
      applyStimulus("resetBranch", s);
      checkOutput("reset.mispForcedLow", {31'b0, ifc.MispredictE}, 32'd0);
      checkOutput("reset.pcIn", ifc.PC_In, 32'h104);

      // Fresh table: no prediction, sequential fetch.
      applyStimulus("postReset", idleStim(32'h100));
      checkOutput("postReset.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);
      checkOutput("postReset.pcIn", ifc.PC_In, 32'h104);

      // Taken branch predicted not-taken: mispredict and allocate.
      applyStimulus("alloc", branchStim(32'h300, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0));
      checkOutput("alloc.misp", {31'b0, ifc.MispredictE}, 32'd1);
      checkOutput("alloc.pcIn", ifc.PC_In, 32'h200);
      applyStimulus("allocHit", idleStim(32'h100));
      checkOutput("allocHit.predTaken", {31'b0, ifc.PredTakenF}, 32'd1);
      checkOutput("allocHit.predTarget", ifc.PredTargetF, 32'h200);
      checkOutput("allocHit.missCount", ifc.MissCount, 32'd1);

      // Two not-taken resolutions walk the counter 10 -> 01 -> 00.
      applyStimulus("ntFirst", branchStim(32'h300, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200));
      checkOutput("ntFirst.misp", {31'b0, ifc.MispredictE}, 32'd1);
      checkOutput("ntFirst.pcIn", ifc.PC_In, 32'h104);
      applyStimulus("ntSecond", branchStim(32'h300, 32'h100, 1'b0, 32'h200, 1'b0, 32'h200));
      checkOutput("ntSecond.misp", {31'b0, ifc.MispredictE}, 32'd0);
      applyStimulus("ntLookup", idleStim(32'h100));
      checkOutput("ntLookup.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);

      // Same index, different tag: the second allocation evicts the first.
      applyStimulus("evict", branchStim(32'h300, 32'h200, 1'b1, 32'h340, 1'b0, 32'h0));
      applyStimulus("evictOld", idleStim(32'h100));
      checkOutput("evictOld.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);
      applyStimulus("evictNew", idleStim(32'h200));
      checkOutput("evictNew.predTarget", ifc.PredTargetF, 32'h340);

      // Train to saturation then back one step: still predicted taken.
      repeat (3) applyStimulus("satUp", branchStim(32'h300, 32'h200, 1'b1, 32'h340, 1'b1, 32'h340));
      applyStimulus("satDown", branchStim(32'h300, 32'h200, 1'b0, 32'h340, 1'b1, 32'h340));
      applyStimulus("satLookup", idleStim(32'h200));
      checkOutput("satLookup.predTaken", {31'b0, ifc.PredTakenF}, 32'd1);

      // Mispredict beats a jal in ID.
      s = branchStim(32'h300, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      s.jalD = 1'b1; s.jalTarget = 32'h900;
      applyStimulus("mispOverJal", s);
      checkOutput("mispOverJal.pcIn", ifc.PC_In, 32'h80);

      // Stalled branch: no mispredict, no table or counter change.
      s = branchStim(32'h300, 32'h44, 1'b1, 32'h88, 1'b0, 32'h0);
      s.stallE = 1'b1;
      applyStimulus("stall", s);
      applyStimulus("stallLookup", idleStim(32'h44));
      checkOutput("stallLookup.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);

      // jalr beats jal, jal beats a taken prediction.
      s = idleStim(32'h200);
      s.jalD = 1'b1; s.jalTarget = 32'h900; s.jalrE = 1'b1; s.jalrTarget = 32'hA00;
      applyStimulus("jalrOverJal", s);
      checkOutput("jalrOverJal.pcIn", ifc.PC_In, 32'hA00);
      s.jalrE = 1'b0;
      applyStimulus("jalOverPred", s);
      checkOutput("jalOverPred.pcIn", ifc.PC_In, 32'h900);

      // Wraparound of the fall-through address.
      applyStimulus("wrapE", branchStim(32'h300, 32'hFFFF_FFFC, 1'b0, 32'h1000, 1'b1, 32'h1000));
      checkOutput("wrapE.pcIn", ifc.PC_In, 32'h0000_0000);
      applyStimulus("wrapF", idleStim(32'hFFFF_FFFC));
      checkOutput("wrapF.pcIn", ifc.PC_In, 32'h0000_0000);

      // Reset arriving during a qualifying update discards it.
      s = branchStim(32'h300, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
      s.rst = 1'b1;
      applyStimulus("midReset", s);
      applyStimulus("midResetLookup", idleStim(32'h600));
      checkOutput("midResetLookup.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);
      applyStimulus("midResetOld", idleStim(32'h200));
      checkOutput("midResetOld.predTaken", {31'b0, ifc.PredTakenF}, 32'd0);

      // Randomised traffic over a handful of conflicting PCs.
      for (int n = 0; n < 300; n++) begin
         s = idleStim((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2));
         s.pce         = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
         s.brInst      = ($urandom_range(0, 3) != 0);
         s.branch      = $urandom_range(0, 1) == 1;
         s.brTarget    = 32'($urandom_range(0, 7)) << 4;
         s.predTakenE  = $urandom_range(0, 1) == 1;
         s.predTargetE = ($urandom_range(0, 1) == 1) ? s.brTarget : (32'($urandom_range(0, 7)) << 4);
         s.jalD        = ($urandom_range(0, 7) == 0);
         s.jalTarget   = 32'h800;
         s.jalrE       = ($urandom_range(0, 7) == 0);
         s.jalrTarget  = 32'hC00;
         s.stallE      = ($urandom_range(0, 5) == 0);
         s.rst         = ($urandom_range(0, 63) == 0);
         applyStimulus("random", s);
      end

      if (sbQ.size() != 0)
         checkOutput("scoreboard.leftover", 32'(sbQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/btb_npc_generator.md
BTB_NPC_GENERATOR -- requirements
Module: btb_npc_generator

Interface
REQ-001 Parameter ENTRIES, default 64; number of BTB entries; power of two, 4..256; IDX_W = log2(ENTRIES).
REQ-002 Parameter CNT_INIT, default 2'b01; counter value loaded into every entry at reset (weakly not-taken).
REQ-003 CPU_CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 CPU_RST  in  1  reset; synchronous, active-high.
REQ-005 PCF  in  32  fetch-stage PC.
REQ-006 PCE  in  32  PC of the instruction in EX.
REQ-007 BrInstE  in  1  the EX instruction is a conditional branch.
REQ-008 BranchE  in  1  the EX branch resolved taken.
REQ-009 BranchTarget  in  32  resolved branch target.
REQ-010 PredTakenE  in  1  prediction made for the EX instruction, carried down the pipeline.
REQ-011 PredTargetE  in  32  predicted target carried with the EX instruction.
REQ-012 JalD / JalTarget  in  1/32  jal in ID and its target.
REQ-013 JalrE / JalrTarget  in  1/32  jalr in EX and its target.
REQ-014 StallE  in  1  EX stalled; blocks BTB update and counter increments.
REQ-015 PC_In  out  32  next PC.
REQ-016 PredTakenF / PredTargetF  out  1/32  prediction for PCF, to be piped to EX.
REQ-017 MispredictE  out  1  EX branch mispredicted; flush request to the hazard unit.
REQ-018 BrCount / MissCount  out  32/32  performance counters.

Function
REQ-019 Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], 2-bit saturating counter; index = PC[IDX_W+1:2]; PC[1:0] ignored.
REQ-020 Lookup is combinational on PCF against registered table contents: hit = valid & tag match; PredTakenF = hit & counter[1]; PredTargetF = entry target on hit, else PCF+4.
REQ-021 MispredictE = BrInstE & ~StallE & ((BranchE != PredTakenE) | (BranchE & PredTakenE & PredTargetE != BranchTarget)).
REQ-022 PC_In priority: MispredictE -> (BranchE ? BranchTarget : PCE+4); else JalrE -> JalrTarget; else JalD -> JalTarget; else PredTakenF -> PredTargetF; else PCF+4.
REQ-023 All +4 additions are modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-024 Update occurs on the clock edge when BrInstE & ~StallE & ~CPU_RST, at index PCE[IDX_W+1:2].
REQ-025 Update on hit: counter +1 saturating at 2'b11 if BranchE, else -1 saturating at 2'b00; target written with BranchTarget when BranchE.
REQ-026 Update on miss: if BranchE, allocate (valid=1, tag, target=BranchTarget, counter=2'b10), overwriting any conflicting entry; if ~BranchE, no change.
REQ-027 Simultaneous lookup and update at the same index: lookup returns pre-update contents; the new contents are visible the next cycle.
REQ-028 BrCount increments on each update-qualifying cycle; MissCount increments when MispredictE=1; both saturate at 0xFFFFFFFF.
REQ-029 jal/jalr never allocate or modify BTB entries.
REQ-030 Latency: prediction 0 cycles (combinational); update visible 1 cycle after the qualifying edge.

Reset
REQ-031 While CPU_RST=1, at every rising edge: all valid bits cleared, counters set to CNT_INIT, targets set to 0, BrCount and MissCount set to 0.
REQ-032 While CPU_RST=1, PredTakenF and MispredictE are forced to 0, and PC_In = PCF+4.
REQ-033 Reset asserted mid-operation discards any pending update in the same cycle; after release, the table behaves as freshly reset.

Verification
REQ-034 After reset, PCF=0x100 -> PredTakenF=0, PC_In=0x104.
REQ-035 Branch at PCE=0x100, BranchE=1, target 0x200, PredTakenE=0 -> MispredictE=1, PC_In=0x200, MissCount=1; the next cycle, PCF=0x100 gives PredTakenF=1, PredTargetF=0x200.
REQ-036 Same branch resolved not-taken twice with predictions matching the counter -> counter 10->01->00; PCF=0x100 then gives PredTakenF=0; MispredictE=1 only on the first (predicted-taken) resolution.
REQ-037 ENTRIES=64: branches at 0x100 and 0x200 (same index, different tag), both taken -> the second allocation evicts the first; PCF=0x100 gives PredTakenF=0.
REQ-038 JalD=1 and MispredictE=1 in the same cycle -> PC_In follows the mispredict; StallE=1 with BrInstE=1 -> no table or counter change.
REQ-039 PCE=0xFFFFFFFC branch predicted taken, resolved not-taken -> PC_In=0x00000000; CPU_RST asserted during a qualifying update -> the entry stays invalid.
